// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 raster timing, 4x4 card grid geometry, symbol codes and card origin helper
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int GRID_COLS = 4;
  localparam int GRID_ROWS = 4;
  localparam int CARD_W = 50;
  localparam int CARD_H = 70;
  localparam int GAP_X = 20;
  localparam int GAP_Y = 20;
  localparam int ORIGIN_X = 100;
  localparam int ORIGIN_Y = 60;
  typedef enum logic [2:0] {
    SYM_PLUS, SYM_MINUS, SYM_CROSS, SYM_SQUARE, SYM_HASH, SYM_CIRCLE, SYM_TRI, SYM_INV_TRI
  } symbol_t;
  typedef struct packed {
    logic [9:0] left;
    logic [9:0] top;
  } card_pos_t;
  function automatic card_pos_t card_pos(input int col, input int row);
    return '{left: 10'(ORIGIN_X + col * (CARD_W + GAP_X)), top: 10'(ORIGIN_Y + row * (CARD_H + GAP_Y))};
  endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: raster counters advancing on pix_en; registered x/y/hsync/vsync/video_on/frame_start plus next-pixel nx/ny/nvon for aligned downstream registers
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] nx,
  output logic [9:0] ny,
  output logic       nvon,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);
  localparam int HS_LO = H_ACTIVE + H_FP;
  localparam int HS_HI = HS_LO + H_SYNC - 1;
  localparam int VS_LO = V_ACTIVE + V_FP;
  localparam int VS_HI = VS_LO + V_SYNC - 1;
  logic [9:0] hc, vc;
  always_comb begin
    nx = hc == 10'(H_TOTAL - 1) ? '0 : hc + 10'd1;
    ny = hc == 10'(H_TOTAL - 1) ? (vc == 10'(V_TOTAL - 1) ? '0 : vc + 10'd1) : vc;
    nvon = nx < 10'(H_ACTIVE) && ny < 10'(V_ACTIVE);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      hc <= 10'(H_TOTAL - 1);
      vc <= 10'(V_TOTAL - 1);
      x <= '0;
      y <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      video_on <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      hc <= nx;
      vc <= ny;
      x <= nx;
      y <= ny;
      hsync <= !(nx >= 10'(HS_LO) && nx <= 10'(HS_HI));
      vsync <= !(ny >= 10'(VS_LO) && ny <= 10'(VS_HI));
      video_on <= nvon;
      frame_start <= nx == '0 && ny == '0;
    end
endmodule

// File: rtl/card_grid_scan.sv
// card_grid_scan: VGA raster source with per-pixel card hit, bounds and frame-snapshotted symbol (in: clk rst_n pix_en board_sym; out: x y hsync vsync video_on frame_start card_valid card_idx left right top bot symbol_sel)
module card_grid_scan
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic [47:0] board_sym,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start,
  output logic        card_valid,
  output logic [3:0]  card_idx,
  output logic [9:0]  left,
  output logic [9:0]  right,
  output logic [9:0]  top,
  output logic [9:0]  bot,
  output logic [2:0]  symbol_sel
);
  if (ORIGIN_X + GRID_COLS * (CARD_W + GAP_X) - GAP_X > H_ACTIVE ||
      ORIGIN_Y + GRID_ROWS * (CARD_H + GAP_Y) - GAP_Y > V_ACTIVE) begin : g_fit
    $error("card grid does not fit in the active area");
  end
  logic [9:0] nx, ny;
  logic nvon, col_hit, row_hit, hit;
  logic [1:0] col, row;
  logic [3:0] idx;
  logic [47:0] shadow;
  card_pos_t p, cp;
  symbol_t sym;
  vga_timing u_timing (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .nx(nx), .ny(ny), .nvon(nvon),
    .x(x), .y(y), .hsync(hsync), .vsync(vsync), .video_on(video_on), .frame_start(frame_start)
  );
  always_comb begin
    p = '0;
    col = '0;
    row = '0;
    col_hit = 1'b0;
    row_hit = 1'b0;
    for (int i = 0; i < GRID_COLS; i++) begin
      p = card_pos(i, 0);
      if (nx >= p.left && nx <= p.left + 10'(CARD_W - 1)) begin
        col_hit = 1'b1;
        col = 2'(i);
      end
    end
    for (int i = 0; i < GRID_ROWS; i++) begin
      p = card_pos(0, i);
      if (ny >= p.top && ny <= p.top + 10'(CARD_H - 1)) begin
        row_hit = 1'b1;
        row = 2'(i);
      end
    end
    hit = nvon && col_hit && row_hit;
    idx = 4'(int'(row) * GRID_COLS + int'(col));
    cp = card_pos(int'(col), int'(row));
    sym = symbol_t'(shadow[3 * int'(idx) +: 3]);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      shadow <= '0;
      card_valid <= 1'b0;
      card_idx <= '0;
      left <= '0;
      right <= '0;
      top <= '0;
      bot <= '0;
      symbol_sel <= '0;
    end else if (pix_en) begin
      if (nx == '0 && ny == '0) shadow <= board_sym;
      card_valid <= hit;
      card_idx <= hit ? idx : '0;
      left <= hit ? cp.left : '0;
      right <= hit ? cp.left + 10'(CARD_W - 1) : '0;
      top <= hit ? cp.top : '0;
      bot <= hit ? cp.top + 10'(CARD_H - 1) : '0;
      symbol_sel <= hit ? 3'(sym) : 3'd0;
    end
endmodule

// File: tb/tb_card_grid_scan.sv
// tb_card_grid_scan: directed raster/card/snapshot/reset vectors with a queue scoreboard checked by a separate monitor
module tb_card_grid_scan;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, pix_en;
  logic [47:0] board_sym;
  logic [9:0] x, y, left, right, top, bot;
  logic hsync, vsync, video_on, frame_start, card_valid;
  logic [3:0] card_idx;
  logic [2:0] symbol_sel;
  card_grid_scan dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .board_sym(board_sym), .x(x), .y(y),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .frame_start(frame_start),
    .card_valid(card_valid), .card_idx(card_idx), .left(left), .right(right), .top(top),
    .bot(bot), .symbol_sel(symbol_sel)
  );
  typedef struct packed {
    logic [9:0] x, y;
    logic hs, vs, von, fs, cv;
    logic [3:0] idx;
    logic [9:0] l, r, t, b;
    logic [2:0] sym;
  } exp_t;
  exp_t q[$];
  string qn[$];
  exp_t e_next, act, exp_v;
  string n_next, n_cur;
  int checks = 0, errors = 0;
  int bx = 0, by = 0;
  bit tog = 1'b0;
  function automatic string fmt(input exp_t e);
    return $sformatf("x=%0d y=%0d hs=%0b vs=%0b von=%0b fs=%0b cv=%0b idx=%0d l=%0d r=%0d t=%0d b=%0d sym=%0d",
                     e.x, e.y, e.hs, e.vs, e.von, e.fs, e.cv, e.idx, e.l, e.r, e.t, e.b, e.sym);
  endfunction
  always @(posedge clk) begin
    #2;
    if (q.size() != 0) begin
      exp_v = q.pop_front();
      n_cur = qn.pop_front();
      act = {x, y, hsync, vsync, video_on, frame_start, card_valid, card_idx, left, right, top, bot, symbol_sel};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL %s: got %s, expected %s", n_cur, fmt(act), fmt(exp_v));
      end
    end
  end
  task automatic step(input bit en, input bit chk);
    pix_en = en;
    if (chk) begin
      q.push_back(e_next);
      qn.push_back(n_next);
    end
    @(posedge clk);
    @(negedge clk);
    if (!rst_n) begin
      bx = 0;
      by = 0;
    end else if (en) begin
      if (bx == 799) begin
        bx = 0;
        by = by == 524 ? 0 : by + 1;
      end else bx++;
    end
  endtask
  task automatic adv(input bit chk);
    if (tog) step(1'b0, 1'b0);
    step(1'b1, chk);
  endtask
  task automatic go_to(input int tx, input int ty);
    while (!(bx == tx && by == ty)) adv(1'b0);
  endtask
  task automatic chk_raster(input string n, input int tx, input int ty, input bit hs, input bit vs, input bit von, input bit fs);
    go_to(tx, ty);
    e_next = '{x: 10'(tx), y: 10'(ty), hs: hs, vs: vs, von: von, fs: fs, default: '0};
    n_next = n;
    adv(1'b1);
  endtask
  task automatic chk_card(input string n, input int tx, input int ty, input int idx, input int l, input int r, input int t, input int b, input int sym);
    go_to(tx, ty);
    e_next = '{x: 10'(tx), y: 10'(ty), hs: 1'b1, vs: 1'b1, von: 1'b1, fs: 1'b0, cv: 1'b1, idx: 4'(idx),
               l: 10'(l), r: 10'(r), t: 10'(t), b: 10'(b), sym: 3'(sym)};
    n_next = n;
    adv(1'b1);
  endtask
  initial begin
    #50_000_000;
    $display("FAIL timeout: simulation did not complete, required completion before 50 ms");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 1'b0;
    pix_en = 1'b0;
    board_sym = '0;
    board_sym[2:0] = 3'd3;
    board_sym[17:15] = 3'd5;
    @(negedge clk);
    e_next = '{hs: 1'b1, vs: 1'b1, default: '0};
    n_next = "reset_hold";
    step(1'b0, 1'b1);
    n_next = "reset_en";
    step(1'b1, 1'b1);
    rst_n = 1'b1;
    chk_raster("first_pixel", 0, 0, 1, 1, 1, 1);
    chk_raster("x1", 1, 0, 1, 1, 1, 0);
    chk_raster("x639", 639, 0, 1, 1, 1, 0);
    chk_raster("x640", 640, 0, 1, 1, 0, 0);
    chk_raster("x655", 655, 0, 1, 1, 0, 0);
    chk_raster("hs_start", 656, 0, 0, 1, 0, 0);
    chk_raster("hs_end", 751, 0, 0, 1, 0, 0);
    chk_raster("x752", 752, 0, 1, 1, 0, 0);
    chk_raster("x799", 799, 0, 1, 1, 0, 0);
    chk_raster("line_wrap", 0, 1, 1, 1, 1, 0);
    chk_card("card0_tl", 100, 60, 0, 100, 149, 60, 129, 3);
    chk_card("card0_right", 149, 60, 0, 100, 149, 60, 129, 3);
    chk_raster("gap_x", 150, 60, 1, 1, 1, 0);
    chk_card("card0_bot", 100, 129, 0, 100, 149, 60, 129, 3);
    chk_raster("gap_y", 100, 130, 1, 1, 1, 0);
    board_sym[17:15] = 3'd2;
    chk_card("card5_f0", 170, 150, 5, 170, 219, 150, 219, 5);
    chk_card("card7_edge", 359, 150, 7, 310, 359, 150, 219, 0);
    chk_raster("right_of_grid", 360, 150, 1, 1, 1, 0);
    chk_card("card15", 359, 399, 15, 310, 359, 330, 399, 0);
    chk_raster("below_grid", 359, 400, 1, 1, 1, 0);
    tog = 1'b1;
    chk_raster("frame1", 0, 0, 1, 1, 1, 1);
    n_next = "hold_raster";
    step(1'b0, 1'b1);
    chk_card("card5_f1", 170, 150, 5, 170, 219, 150, 219, 2);
    n_next = "hold_card";
    step(1'b0, 1'b1);
    chk_raster("y489", 799, 489, 1, 1, 0, 0);
    chk_raster("vs_start", 0, 490, 1, 0, 0, 0);
    chk_raster("vs_end", 799, 491, 1, 0, 0, 0);
    chk_raster("y492", 0, 492, 1, 1, 0, 0);
    chk_raster("last_pixel", 799, 524, 1, 1, 0, 0);
    chk_raster("frame2", 0, 0, 1, 1, 1, 1);
    tog = 1'b0;
    chk_raster("pre_reset", 300, 200, 1, 1, 1, 0);
    rst_n = 1'b0;
    e_next = '{hs: 1'b1, vs: 1'b1, default: '0};
    n_next = "mid_reset";
    step(1'b1, 1'b1);
    rst_n = 1'b1;
    chk_raster("after_reset", 0, 0, 1, 1, 1, 1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations pending, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
